conditionneur_boutons: RTL and testbench

- Conditions the two raw player push-buttons (plus and minus) before they reach the paddle controller that moves the falling brick between columns.
- Per button: 2-flop synchronisation, debounce, then a one-cycle move pulse on press, with auto-repeat while held.
- Sits between the board pins and the paddle-controller button inputs; replaces direct use of raw button levels.
- Also exports the debounced levels for the score/display logic.

---
 rtl/conditionneur_boutons.sv | 185 ++++++++++++++++++
 tb/tb_conditionneur_boutons.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/conditionneur_boutons.sv
// conditionneur_boutons
// Conditions the raw plus/minus push-buttons for the paddle controller.
// Each channel: two-flop synchroniser, debounce counter producing a clean
// level (etat), and a three-state repeat machine that emits one move pulse
// on press, then auto-repeat pulses while the button stays held. Pulses
// that fire on both channels in the same cycle cancel each other at the
// output, while both repeat machines keep their own cadence.

module conditionneur_boutons #(
    parameter int DEBOUNCE      = 500000,
    parameter int REPEAT_DELAY  = 20000000,
    parameter int REPEAT_PERIOD = 7500000,
    parameter int CNT_WIDTH     = 25
) (
    input  logic clk,
    input  logic reset,
    input  logic boutonPlus,
    input  logic boutonMoins,
    output logic impulsionPlus,
    output logic impulsionMoins,
    output logic etatPlus,
    output logic etatMoins
);

    // Channel 0 is plus, channel 1 is minus.
    localparam int NB_CANAUX = 2;

    // Terminal counts, expressed at counter width so comparisons are exact.
    localparam logic [CNT_WIDTH-1:0] DEB_FIN     = CNT_WIDTH'(DEBOUNCE - 1);
    localparam logic [CNT_WIDTH-1:0] DELAI_FIN   = CNT_WIDTH'(REPEAT_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] PERIODE_FIN = CNT_WIDTH'(REPEAT_PERIOD - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_UN      = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        RELACHE    = 2'd0,
        ATTENTE    = 2'd1,
        REPETITION = 2'd2
    } etat_fsm_t;

    logic [NB_CANAUX-1:0] bouton_brut;
    logic [NB_CANAUX-1:0] etat_vec;
    logic [NB_CANAUX-1:0] impulsion_brute;

    logic impulsion_plus_q;
    logic impulsion_moins_q;

    assign bouton_brut = {boutonMoins, boutonPlus};

    generate
        for (genvar gi = 0; gi < NB_CANAUX; gi++) begin : g_canal
            logic                 sync1_q;
            logic                 sync2_q;
            logic                 etat_q;
            logic                 etat_d;
            logic [CNT_WIDTH-1:0] deb_cnt_q;
            logic [CNT_WIDTH-1:0] deb_cnt_d;
            logic [CNT_WIDTH-1:0] rep_cnt_q;
            etat_fsm_t            fsm_q;
            logic                 montee;
            logic                 descente;
            logic                 fin_delai;
            logic                 fin_periode;
            logic                 brute;

            // Two-flop synchroniser for the asynchronous raw button.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                end else begin
                    sync1_q <= bouton_brut[gi];
                    sync2_q <= sync1_q;
                end
            end

            // Debounce next state: a disagreement must persist DEBOUNCE
            // consecutive cycles before the clean level flips.
            always_comb begin
                deb_cnt_d = deb_cnt_q;
                etat_d    = etat_q;
                if (sync2_q == etat_q) begin
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_FIN) begin
                    etat_d    = ~etat_q;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + CNT_UN;
                end
            end

            // Debounce state registers (clean level and stability counter).
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    etat_q    <= 1'b0;
                    deb_cnt_q <= '0;
                end else begin
                    etat_q    <= etat_d;
                    deb_cnt_q <= deb_cnt_d;
                end
            end

            // Edges are taken on the next clean level so that the pulse and
            // the level change land on the same clock edge.
            assign montee      = etat_d & ~etat_q;
            assign descente    = ~etat_d & etat_q;
            assign fin_delai   = (rep_cnt_q == DELAI_FIN);
            assign fin_periode = (rep_cnt_q == PERIODE_FIN);

            // Raw move pulse of this channel, before conflict masking; a
            // release always beats a repeat scheduled on the same edge.
            always_comb begin
                brute = 1'b0;
                case (fsm_q)
                    RELACHE:    brute = montee;
                    ATTENTE:    brute = ~descente & fin_delai;
                    REPETITION: brute = ~descente & fin_periode;
                    default:    brute = 1'b0;
                endcase
            end

            // Repeat machine: first pulse on press, one after the initial
            // delay, then one every period until the clean level falls.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    fsm_q     <= RELACHE;
                    rep_cnt_q <= '0;
                end else begin
                    case (fsm_q)
                        RELACHE: begin
                            if (montee) begin
                                fsm_q     <= ATTENTE;
                                rep_cnt_q <= '0;
                            end
                        end
                        ATTENTE: begin
                            if (descente) begin
                                fsm_q     <= RELACHE;
                                rep_cnt_q <= '0;
                            end else if (fin_delai) begin
                                fsm_q     <= REPETITION;
                                rep_cnt_q <= '0;
                            end else begin
                                rep_cnt_q <= rep_cnt_q + CNT_UN;
                            end
                        end
                        REPETITION: begin
                            if (descente) begin
                                fsm_q     <= RELACHE;
                                rep_cnt_q <= '0;
                            end else if (fin_periode) begin
                                rep_cnt_q <= '0;
                            end else begin
                                rep_cnt_q <= rep_cnt_q + CNT_UN;
                            end
                        end
                        default: begin
                            fsm_q     <= RELACHE;
                            rep_cnt_q <= '0;
                        end
                    endcase
                end
            end

            assign impulsion_brute[gi] = brute;
            assign etat_vec[gi]        = etat_q;
        end
    endgenerate

    // Output pulse registers: simultaneous pulses on both channels cancel.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            impulsion_plus_q  <= 1'b0;
            impulsion_moins_q <= 1'b0;
        end else begin
            impulsion_plus_q  <= impulsion_brute[0] & ~impulsion_brute[1];
            impulsion_moins_q <= impulsion_brute[1] & ~impulsion_brute[0];
        end
    end

    assign impulsionPlus  = impulsion_plus_q;
    assign impulsionMoins = impulsion_moins_q;
    assign etatPlus       = etat_vec[0];
    assign etatMoins      = etat_vec[1];

endmodule

// File: tb/tb_conditionneur_boutons.sv
// Directed bench for conditionneur_boutons with DEBOUNCE=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3. Tick k means the k-th rising edge after the stimulus
// starts; the raw level set before tick k is what that edge samples, so a
// press first sampled at tick 1 yields etat and pulse after tick 6.

module tb_conditionneur_boutons;

    logic clk = 1'b0;
    logic reset;
    logic boutonPlus;
    logic boutonMoins;
    logic impulsionPlus;
    logic impulsionMoins;
    logic etatPlus;
    logic etatMoins;

    int checks = 0;
    int errors = 0;

    conditionneur_boutons #(
        .DEBOUNCE      (4),
        .REPEAT_DELAY  (10),
        .REPEAT_PERIOD (3),
        .CNT_WIDTH     (8)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .boutonPlus     (boutonPlus),
        .boutonMoins    (boutonMoins),
        .impulsionPlus  (impulsionPlus),
        .impulsionMoins (impulsionMoins),
        .etatPlus       (etatPlus),
        .etatMoins      (etatMoins)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reset with both buttons released; leaves reset low just after an edge.
    task automatic apply_reset;
        reset       = 1'b1;
        boutonPlus  = 1'b0;
        boutonMoins = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        logic [3:0] exp_v;
        apply_reset();
        checks++;
        if ({impulsionPlus, etatPlus, impulsionMoins, etatMoins} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state got %b exp 0000",
                     {impulsionPlus, etatPlus, impulsionMoins, etatMoins});
        end
        // Press both and hold until both levels are accepted.
        for (int k = 1; k <= 8; k++) begin
            boutonPlus  = 1'b1;
            boutonMoins = 1'b1;
            tick();
        end
        checks++;
        if ({etatPlus, etatMoins} !== 2'b11) begin
            errors++;
            $display("FAIL reset_preheld got etat %b exp 11", {etatPlus, etatMoins});
        end
        // Asynchronous reset mid-cycle.
        #3;
        reset = 1'b1;
        #1;
        checks++;
        if ({impulsionPlus, etatPlus, impulsionMoins, etatMoins} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_async got %b exp 0000",
                     {impulsionPlus, etatPlus, impulsionMoins, etatMoins});
        end
        boutonMoins = 1'b0;
        tick();
        tick();
        #3;
        reset = 1'b0;
        // Plus still held: fresh press, full debounce, pulse at tick 6.
        for (int k = 1; k <= 9; k++) begin
            tick();
            exp_v = {(k == 6), (k >= 6), 1'b0, 1'b0};
            checks++;
            if ({impulsionPlus, etatPlus, impulsionMoins, etatMoins} !== exp_v) begin
                errors++;
                $display("FAIL reset_release k=%0d got %b exp %b", k,
                         {impulsionPlus, etatPlus, impulsionMoins, etatMoins}, exp_v);
            end
        end
    endtask

    task automatic test_clean_press;
        logic [3:0] exp_v;
        apply_reset();
        for (int k = 1; k <= 18; k++) begin
            boutonPlus = (k <= 8);
            tick();
            exp_v = {(k == 6), (k >= 6 && k <= 13), 1'b0, 1'b0};
            checks++;
            if ({impulsionPlus, etatPlus, impulsionMoins, etatMoins} !== exp_v) begin
                errors++;
                $display("FAIL clean_press k=%0d got %b exp %b", k,
                         {impulsionPlus, etatPlus, impulsionMoins, etatMoins}, exp_v);
            end
        end
    endtask

    task automatic test_bounce;
        logic [5:0] motif;
        logic [3:0] exp_v;
        motif = 6'b101101;
        apply_reset();
        for (int k = 1; k <= 22; k++) begin
            if (k <= 6) boutonPlus = motif[6-k];
            else        boutonPlus = (k <= 14);
            tick();
            exp_v = {(k == 11), (k >= 11 && k <= 19), 1'b0, 1'b0};
            checks++;
            if ({impulsionPlus, etatPlus, impulsionMoins, etatMoins} !== exp_v) begin
                errors++;
                $display("FAIL bounce k=%0d got %b exp %b", k,
                         {impulsionPlus, etatPlus, impulsionMoins, etatMoins}, exp_v);
            end
        end
    endtask

    // A pulse of exactly DEBOUNCE cycles is accepted.
    task automatic test_debounce_boundary;
        logic [3:0] exp_v;
        apply_reset();
        for (int k = 1; k <= 12; k++) begin
            boutonPlus = (k <= 4);
            tick();
            exp_v = {(k == 6), (k >= 6 && k <= 9), 1'b0, 1'b0};
            checks++;
            if ({impulsionPlus, etatPlus, impulsionMoins, etatMoins} !== exp_v) begin
                errors++;
                $display("FAIL debounce_boundary k=%0d got %b exp %b", k,
                         {impulsionPlus, etatPlus, impulsionMoins, etatMoins}, exp_v);
            end
        end
    endtask

    // Held 40 cycles: pulses 6,16,19,...,43; release lands on tick 46,
    // which is also a repeat slot and must give no pulse.
    task automatic test_auto_repeat;
        logic [3:0] exp_v;
        logic       exp_p;
        apply_reset();
        for (int k = 1; k <= 50; k++) begin
            boutonMoins = (k <= 40);
            tick();
            exp_p = (k == 6) || (k >= 16 && k <= 45 && ((k - 16) % 3) == 0);
            exp_v = {1'b0, 1'b0, exp_p, (k >= 6 && k <= 45)};
            checks++;
            if ({impulsionPlus, etatPlus, impulsionMoins, etatMoins} !== exp_v) begin
                errors++;
                $display("FAIL auto_repeat k=%0d got %b exp %b", k,
                         {impulsionPlus, etatPlus, impulsionMoins, etatMoins}, exp_v);
            end
        end
    endtask

    task automatic test_conflict;
        logic [3:0] exp_v;
        logic       ee;
        apply_reset();
        for (int k = 1; k <= 38; k++) begin
            boutonPlus  = (k <= 30);
            boutonMoins = (k <= 30);
            tick();
            ee    = (k >= 6 && k <= 35);
            exp_v = {1'b0, ee, 1'b0, ee};
            checks++;
            if ({impulsionPlus, etatPlus, impulsionMoins, etatMoins} !== exp_v) begin
                errors++;
                $display("FAIL conflict k=%0d got %b exp %b", k,
                         {impulsionPlus, etatPlus, impulsionMoins, etatMoins}, exp_v);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] exp_v;
        logic       pp;
        logic       pm;
        apply_reset();
        for (int k = 1; k <= 30; k++) begin
            boutonPlus  = (k <= 20);
            boutonMoins = (k >= 2 && k <= 21);
            tick();
            pp    = (k == 6) || (k >= 16 && k <= 25 && ((k - 16) % 3) == 0);
            pm    = (k == 7) || (k >= 17 && k <= 26 && ((k - 17) % 3) == 0);
            exp_v = {pp, (k >= 6 && k <= 25), pm, (k >= 7 && k <= 26)};
            checks++;
            if ({impulsionPlus, etatPlus, impulsionMoins, etatMoins} !== exp_v) begin
                errors++;
                $display("FAIL back_to_back k=%0d got %b exp %b", k,
                         {impulsionPlus, etatPlus, impulsionMoins, etatMoins}, exp_v);
            end
        end
    endtask

    task automatic test_glitch_reset_release;
        reset       = 1'b1;
        boutonPlus  = 1'b1;
        boutonMoins = 1'b0;
        tick();
        tick();
        #3;
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            boutonPlus = (k <= 3);
            tick();
            checks++;
            if ({impulsionPlus, etatPlus, impulsionMoins, etatMoins} !== 4'b0000) begin
                errors++;
                $display("FAIL glitch_reset_release k=%0d got %b exp 0000", k,
                         {impulsionPlus, etatPlus, impulsionMoins, etatMoins});
            end
        end
    endtask

    initial begin
        reset       = 1'b1;
        boutonPlus  = 1'b0;
        boutonMoins = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_debounce_boundary();
        test_auto_repeat();
        test_conflict();
        test_back_to_back();
        test_glitch_reset_release();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
